// File: rtl/fetch_stage.sv
// IF stage: owns the PC, issues single-outstanding instruction reads and fills the IF/ID register.
// Responses made stale by a redirect are dropped so ID only ever sees correct-path work or bubbles.
module fetch_stage #(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h0000_0013)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            flush,
    input  logic [XLEN-1:0] branch_target,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] ifid_pc,
    output logic [XLEN-1:0] ifid_instr,
    output logic            ifid_valid
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_DROP = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] hold_instr_q, hold_instr_d;
    logic            req_q, req_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] ifid_pc_q, ifid_pc_d;
    logic [XLEN-1:0] ifid_instr_q, ifid_instr_d;
    logic            ifid_valid_q, ifid_valid_d;

    logic [XLEN-1:0] target_c;
    logic [XLEN-1:0] pc_inc_c;
    logic            complete_c;
    logic [XLEN-1:0] load_instr_c;

    assign target_c = branch_target & ~XLEN'(3);
    assign pc_inc_c = pc_q + XLEN'(4);

    // Next-state logic. req_q is low only in the first REQ cycle after reset, when nothing has been issued yet.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        hold_instr_d = hold_instr_q;
        complete_c   = 1'b0;
        load_instr_c = imem_rdata;

        case (state_q)
            S_REQ: begin
                if (flush) begin
                    pc_d = target_c;
                end
                if (req_q) begin
                    state_d = flush ? S_DROP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (flush) begin
                    pc_d    = target_c;
                    state_d = imem_rvalid ? S_REQ : S_DROP;
                end else if (imem_rvalid) begin
                    if (stall) begin
                        hold_instr_d = imem_rdata;
                        state_d      = S_HOLD;
                    end else begin
                        complete_c = 1'b1;
                        pc_d       = pc_inc_c;
                        state_d    = S_REQ;
                    end
                end
            end
            S_HOLD: begin
                if (flush) begin
                    pc_d    = target_c;
                    state_d = S_REQ;
                end else if (!stall) begin
                    complete_c   = 1'b1;
                    load_instr_c = hold_instr_q;
                    pc_d         = pc_inc_c;
                    state_d      = S_REQ;
                end
            end
            S_DROP: begin
                if (flush) begin
                    pc_d = target_c;
                end
                if (imem_rvalid) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase

        // IF/ID: flush beats stall beats completion; otherwise a bubble with the PC held.
        ifid_pc_d    = ifid_pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_valid_d = ifid_valid_q;
        if (flush) begin
            ifid_pc_d    = '0;
            ifid_instr_d = NOP_INSTR;
            ifid_valid_d = 1'b0;
        end else if (!stall) begin
            if (complete_c) begin
                ifid_pc_d    = pc_q;
                ifid_instr_d = load_instr_c;
                ifid_valid_d = 1'b1;
            end else begin
                ifid_instr_d = NOP_INSTR;
                ifid_valid_d = 1'b0;
            end
        end

        req_d  = (state_d == S_REQ);
        addr_d = pc_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_REQ;
            pc_q         <= RESET_PC;
            hold_instr_q <= NOP_INSTR;
            req_q        <= 1'b0;
            addr_q       <= RESET_PC;
            ifid_pc_q    <= '0;
            ifid_instr_q <= NOP_INSTR;
            ifid_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            hold_instr_q <= hold_instr_d;
            req_q        <= req_d;
            addr_q       <= addr_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_valid_q <= ifid_valid_d;
        end
    end

    assign imem_req   = req_q;
    assign imem_addr  = addr_q;
    assign ifid_pc    = ifid_pc_q;
    assign ifid_instr = ifid_instr_q;
    assign ifid_valid = ifid_valid_q;

endmodule
